// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder: operands are streamed LSB nibble first through a
// single 4-bit carry-lookahead slice, with the slice carry registered between nibbles.

module cla_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       CI,
  output logic [3:0] SUM,
  output logic       CO
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = A & B;
  assign p_s = A ^ B;

  // Two-level lookahead carries; every carry depends only on g/p and CI.
  always_comb begin
    c_s    = 5'd0;
    c_s[0] = CI;
    c_s[1] = g_s[0] | (p_s[0] & CI);
    c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & CI);
    c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
           | (p_s[2] & p_s[1] & p_s[0] & CI);
    c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
           | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
           | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & CI);
  end

  assign SUM = p_s ^ c_s[3:0];
  assign CO  = c_s[4];

endmodule

module cla_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             CO,
  output logic             OVF
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             sign_a_q;
  logic             sign_b_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] sum_out_q;
  logic             co_q;
  logic             ovf_q;

  logic [3:0]       slice_sum_s;
  logic             slice_co_s;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] opa_d;
  logic [WIDTH-1:0] opb_d;
  logic [IDXW-1:0]  idx_d;
  logic             last_s;
  logic             ovf_d;

  cla_adder u_slice (
    .A   (opa_q[3:0]),
    .B   (opb_q[3:0]),
    .CI  (carry_q),
    .SUM (slice_sum_s),
    .CO  (slice_co_s)
  );

  // The newest slice result enters at the top, so after NIBBLES shifts the
  // first (LSB) nibble has reached bits [3:0].
  generate
    if (WIDTH == 4) begin : g_single
      assign sum_d = slice_sum_s;
    end else begin : g_multi
      assign sum_d = {slice_sum_s, sum_q[WIDTH-1:4]};
    end
  endgenerate

  // Datapath next values for one RUN step.
  always_comb begin
    opa_d  = opa_q >> 4;
    opb_d  = opb_q >> 4;
    idx_d  = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
    last_s = (idx_q == IDXW'(NIBBLES - 1));
    ovf_d  = (sign_a_q == sign_b_q) & (sum_d[WIDTH-1] != sign_a_q);
  end

  // Control FSM with operand/partial-sum registers and registered results.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      idx_q     <= '0;
      sum_out_q <= '0;
      co_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID) begin
            opa_q    <= A;
            opb_q    <= B;
            carry_q  <= CI;
            sign_a_q <= A[WIDTH-1];
            sign_b_q <= B[WIDTH-1];
            idx_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_co_s;
          opa_q   <= opa_d;
          opb_q   <= opb_d;
          idx_q   <= idx_d;
          if (last_s) begin
            sum_out_q <= sum_d;
            co_q      <= slice_co_s;
            ovf_q     <= ovf_d;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign SUM       = sum_out_q;
  assign CO        = co_q;
  assign OVF       = ovf_q;

endmodule
